// File: rtl/change_dispenser.sv
// Coin-change dispenser: pays an amount as 10-unit then 5-unit coin strobes.
// Optional hopper stock tracking and refill enabled by defining CHANGE_INV_EN.
module change_dispenser #(
  parameter int AMT_W     = 11,
  parameter int CNT_W     = 8,
  parameter int PULSE_GAP = 2,
  parameter int INIT_FIVE = 20,
  parameter int INIT_TEN  = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  output logic             ready,
  output logic             ten_pulse,
  output logic             five_pulse,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remain,
  input  logic             refill_ten,
  input  logic             refill_five,
  output logic [CNT_W-1:0] ten_cnt,
  output logic [CNT_W-1:0] five_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TEN  = 3'd1;
  localparam logic [2:0] S_FIVE = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [AMT_W-1:0] TEN_AMT  = AMT_W'(10);
  localparam logic [AMT_W-1:0] FIVE_AMT = AMT_W'(5);
  localparam logic [3:0]       GAP_LAST = (PULSE_GAP == 0) ? 4'd0 : 4'(PULSE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [2:0]       state, state_next;
  logic [AMT_W-1:0] rem, rem_next;
  logic             ret_five, ret_five_next;
  logic [3:0]       gap_cnt, gap_cnt_next;
  logic [AMT_W-1:0] remain_next;
  logic             short_next;
  logic             ten_dec, five_dec;
  logic [CNT_W-1:0] ten_cnt_next, five_cnt_next;
  logic             ten_ok_next, five_ok_next;
  logic             ten_pulse_next, five_pulse_next;

  always_comb begin
    state_next    = state;
    rem_next      = rem;
    ret_five_next = ret_five;
    gap_cnt_next  = gap_cnt;
    remain_next   = remain;
    short_next    = short;
    ten_dec       = 1'b0;
    five_dec      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && ready) begin
          rem_next   = amount;
          state_next = S_TEN;
        end
      end
      // The strobe flop already holds this cycle's dispense decision.
      S_TEN: begin
        if (ten_pulse) begin
          rem_next      = rem - TEN_AMT;
          ten_dec       = 1'b1;
          ret_five_next = 1'b0;
          gap_cnt_next  = 4'd0;
          state_next    = (PULSE_GAP == 0) ? S_TEN : S_GAP;
        end else begin
          state_next = S_FIVE;
        end
      end
      S_FIVE: begin
        if (five_pulse) begin
          rem_next      = rem - FIVE_AMT;
          five_dec      = 1'b1;
          ret_five_next = 1'b1;
          gap_cnt_next  = 4'd0;
          state_next    = (PULSE_GAP == 0) ? S_FIVE : S_GAP;
        end else begin
          remain_next = rem;
          short_next  = (rem != '0);
          state_next  = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = ret_five ? S_FIVE : S_TEN;
        end else begin
          gap_cnt_next = gap_cnt + 4'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

`ifdef CHANGE_INV_EN
  // Simultaneous refill and dispense cancel out.
  always_comb begin
    ten_cnt_next = ten_cnt;
    case ({refill_ten, ten_dec})
      2'b10:   ten_cnt_next = (ten_cnt == CNT_MAX) ? ten_cnt : ten_cnt + 1'b1;
      2'b01:   ten_cnt_next = ten_cnt - 1'b1;
      default: ten_cnt_next = ten_cnt;
    endcase
    five_cnt_next = five_cnt;
    case ({refill_five, five_dec})
      2'b10:   five_cnt_next = (five_cnt == CNT_MAX) ? five_cnt : five_cnt + 1'b1;
      2'b01:   five_cnt_next = five_cnt - 1'b1;
      default: five_cnt_next = five_cnt;
    endcase
  end
  assign ten_ok_next  = (ten_cnt_next != '0);
  assign five_ok_next = (five_cnt_next != '0);
`else
  assign ten_cnt_next  = ten_cnt;
  assign five_cnt_next = five_cnt;
  assign ten_ok_next   = 1'b1;
  assign five_ok_next  = 1'b1;
  wire unused_inv = &{1'b0, refill_ten, refill_five, ten_dec, five_dec};
`endif

  // Strobes are decided one edge early so they leave straight from flops.
  assign ten_pulse_next  = (state_next == S_TEN) && (rem_next >= TEN_AMT) && ten_ok_next;
  assign five_pulse_next = (state_next == S_FIVE) && (rem_next >= FIVE_AMT) && five_ok_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rem        <= '0;
      ret_five   <= 1'b0;
      gap_cnt    <= 4'd0;
      ready      <= 1'b1;
      ten_pulse  <= 1'b0;
      five_pulse <= 1'b0;
      done       <= 1'b0;
      short      <= 1'b0;
      remain     <= '0;
      ten_cnt    <= CNT_W'(INIT_TEN);
      five_cnt   <= CNT_W'(INIT_FIVE);
    end else begin
      state      <= state_next;
      rem        <= rem_next;
      ret_five   <= ret_five_next;
      gap_cnt    <= gap_cnt_next;
      ready      <= (state_next == S_IDLE);
      ten_pulse  <= ten_pulse_next;
      five_pulse <= five_pulse_next;
      done       <= (state_next == S_DONE);
      short      <= short_next;
      remain     <= remain_next;
      ten_cnt    <= ten_cnt_next;
      five_cnt   <= five_cnt_next;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a reference model queues the expected
// strobes and done per request; a negedge monitor pops and compares them.
module tb_change_dispenser;
  localparam int AMT_W = 11;
  localparam int CNT_W = 8;
  localparam int G     = 2;
  localparam int INIT  = 20;
`ifdef CHANGE_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             ready, ten_pulse, five_pulse, done, short;
  logic [AMT_W-1:0] remain;
  logic             refill_ten, refill_five;
  logic [CNT_W-1:0] ten_cnt, five_cnt;

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .PULSE_GAP(G),
                     .INIT_FIVE(INIT), .INIT_TEN(INIT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .amount(amount), .ready(ready),
    .ten_pulse(ten_pulse), .five_pulse(five_pulse), .done(done), .short(short),
    .remain(remain), .refill_ten(refill_ten), .refill_five(refill_five),
    .ten_cnt(ten_cnt), .five_cnt(five_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int cyc; int rem; int sh; } ev_t;
  ev_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc = 0;
  int ten_seen = 0;
  int m_ten = INIT;
  int m_five = INIT;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      check("spurious_event", kind, 99);
    end else begin
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc - acc + 1, e.cyc);
      if (kind == 2) begin
        check("remain", remain, e.rem);
        check("short", short, e.sh);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (ten_pulse && five_pulse) check("pulse_overlap", 1, 0);
      if (ten_pulse) begin
        ten_seen++;
        expect_ev(0);
      end
      if (five_pulse) expect_ev(1);
      if (done) expect_ev(2);
    end
  end

  // Reference model: greedy payout with the cycle at which each event lands.
  task automatic push_model(input int amt);
    int k;
    int r;
    k = 1;
    r = amt;
    while (r >= 10 && (!INV || m_ten > 0)) begin
      q.push_back('{0, k, 0, 0});
      k += 1 + G;
      r -= 10;
      if (INV) m_ten--;
    end
    k++;
    while (r >= 5 && (!INV || m_five > 0)) begin
      q.push_back('{1, k, 0, 0});
      k += 1 + G;
      r -= 5;
      if (INV) m_five--;
    end
    k++;
    q.push_back('{2, k, r, (r != 0) ? 1 : 0});
  endtask

  task automatic accept(input int amt);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", ready, 1);
    req = 1'b1;
    amount = AMT_W'(amt);
    @(posedge clk);
    #1;
    acc = cyc;
    req = 1'b0;
    push_model(amt);
  endtask

  task automatic pay(input int amt);
    int n;
    accept(amt);
    @(negedge clk);
    check("busy_ready", ready, 0);
    req = 1'b1;
    amount = AMT_W'(amt + 5);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      check("payout_timeout", q.size(), 0);
      q.delete();
    end
    check("ready_in_done", ready, 0);
    @(negedge clk);
    check("ready_after_done", ready, 1);
    check("done_strobe_len", done, 0);
    check("ten_cnt", ten_cnt, m_ten);
    check("five_cnt", five_cnt, m_five);
    $display("payout amount=%0d remain=%0d short=%0d ten_cnt=%0d five_cnt=%0d",
             amt, remain, short, ten_cnt, five_cnt);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_ten_pulse"}, ten_pulse, 0);
    check({tag, "_five_pulse"}, five_pulse, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_short"}, short, 0);
    check({tag, "_remain"}, remain, 0);
    check({tag, "_ten_cnt"}, ten_cnt, INIT);
    check({tag, "_five_cnt"}, five_cnt, INIT);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    req = 1'b0;
    amount = '0;
    refill_ten = 1'b0;
    refill_five = 1'b0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Abort mid-payout: reset after the second ten strobe.
    accept(50);
    n = 0;
    while (ten_seen < 2 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_ten_seen", ten_seen, 2);
    reset_n = 1'b0;
    #1;
    check_reset_state("abort");
    q.delete();
    m_ten = INIT;
    m_five = INIT;
    repeat (3) @(negedge clk);
    check("abort_no_done", done, 0);
    reset_n = 1'b1;
    #1;
    check("abort_ready_after", ready, 1);
    $display("payout amount=50 aborted by reset after 2 ten strobes");

    pay(35);
    pay(7);
    pay(0);
    pay(160);
    pay(40);
    pay(m_five * 5);
    pay(15);

    @(negedge clk);
    refill_five = 1'b1;
    repeat (3) @(negedge clk);
    refill_five = 1'b0;
    if (INV) m_five += 3;
    #1;
    check("refill_five_cnt", five_cnt, m_five);
    $display("refill five x3 five_cnt=%0d", five_cnt);

    refill_ten = 1'b1;
    repeat (300) @(negedge clk);
    refill_ten = 1'b0;
    if (INV) m_ten = 255;
    #1;
    check("refill_ten_sat", ten_cnt, m_ten);
    $display("refill ten x300 ten_cnt=%0d", ten_cnt);

    pay(20);
    pay(15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-change dispenser for the vending machine. It takes a change request (amount in currency units) from the sale controller and pays it out as single-cycle coin strobes to the 10-unit and 5-unit hoppers, using the largest coin first. It reports completion, any undispensed remainder and, optionally, hopper stock levels. It is the payout end of the controller's change path.

## Interface
Parameters:
- AMT_W, 11, width of amount and remainder (matches the controller's money register)
- CNT_W, 8, width of hopper stock counters
- PULSE_GAP, 2, idle cycles after each coin strobe (hopper settle time); legal range 0..15
- INIT_FIVE, 20, 5-unit stock loaded at reset
- INIT_TEN, 20, 10-unit stock loaded at reset

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  change request; accepted on a rising edge where req=1 and ready=1
- amount  in  AMT_W  change to pay, sampled on acceptance
- ready  out  1  idle, can accept req
- ten_pulse  out  1  one-cycle strobe, one 10-unit coin
- five_pulse  out  1  one-cycle strobe, one 5-unit coin
- done  out  1  one-cycle strobe, payout finished
- short  out  1  valid with done; 1 = remain nonzero
- remain  out  AMT_W  undispensed amount; valid with done, held until next acceptance
- refill_ten  in  1  add one 10-unit coin to stock (CHANGE_INV_EN only)
- refill_five  in  1  add one 5-unit coin to stock (CHANGE_INV_EN only)
- ten_cnt  out  CNT_W  10-unit stock
- five_cnt  out  CNT_W  5-unit stock

## Operation
- Reset values: ready=1, ten_pulse=0, five_pulse=0, done=0, short=0, remain=0, ten_cnt=INIT_TEN, five_cnt=INIT_FIVE, state IDLE, working remainder rem=0.
- States: IDLE, TEN, FIVE, GAP, DONE.
- IDLE: ready=1. On accept: rem<=amount, go to TEN. A req while ready=0 is ignored (not queued).
- TEN: if rem>=10 and ten_cnt>0: ten_pulse=1 this cycle, rem-=10, ten_cnt-=1, go to GAP (return target TEN). Otherwise go to FIVE with no strobe in that cycle.
- FIVE: if rem>=5 and five_cnt>0: five_pulse=1, rem-=5, five_cnt-=1, go to GAP (return target FIVE). Otherwise go to DONE.
- GAP: counts PULSE_GAP cycles, then returns to its target. With PULSE_GAP=0, GAP is skipped.
- DONE: done=1 for one cycle, remain<=rem, short<=(rem!=0), then IDLE.
- Amounts that are not a multiple of 5 leave a 1..4 remainder, so short=1.
- All arithmetic is unsigned. rem never underflows because every decrement is guarded by its compare.
- Refill: each refill strobe adds 1 to its counter, saturating at 2^CNT_W-1. If a refill and a decrement hit the same counter in the same cycle, the count is unchanged.
- Reset asserted mid-payout aborts immediately: all outputs and stock return to their reset values, and no done is issued.

## Timing
- Accept edge = cycle 0. ready=0 from cycle 1.
- Each coin occupies 1 strobe cycle plus PULSE_GAP gap cycles.
- TEN→FIVE and FIVE→DONE exhaustion checks each cost 1 cycle.
- Payout of t tens and f fives: done asserts at cycle 1 + (t+f)·(1+PULSE_GAP) + 2. With PULSE_GAP=2, amount 35 gives done at cycle 15.
- ready=1 in the cycle after done. A new req can be accepted on that edge.
- Strobes are registered outputs, never combinational from req.
- ten_pulse and five_pulse are never high together.

## Configuration
- CHANGE_INV_EN defined: stock counters are live as described, a coin is dispensed only when its stock is >0, and refill inputs are honoured.
- CHANGE_INV_EN undefined: stock is treated as unlimited. ten_cnt and five_cnt are held at INIT_TEN and INIT_FIVE, refill inputs are ignored, and short=1 only for non-multiple-of-5 amounts.

## Test plan
- PULSE_GAP=2, full stock, amount=35 → 3 ten_pulse then 1 five_pulse, each 3 cycles apart; done at cycle 15; short=0, remain=0; ten_cnt=17, five_cnt=19.
- CHANGE_INV_EN, ten_cnt=1, amount=40 → 1 ten_pulse then 6 five_pulse; short=0; ten_cnt=0, five_cnt=14.
- amount=7 → 1 five_pulse; done with short=1, remain=2.
- amount=0 → no strobes; done at cycle 3; short=0.
- CHANGE_INV_EN, five_cnt=0, ten_cnt=0, amount=15 → no strobes; short=1, remain=15. Then refill_five held 3 cycles → five_cnt=3.
- amount=50, reset_n pulled low after the 2nd ten_pulse → all outputs return to reset values, stock returns to INIT; no done. After release, ready=1 and a new req is accepted normally.
